// File: rtl/dram_cmd_sched.sv
`default_nettype none
// dram_cmd_sched: arbitrates the DRAM command port between host traffic and a
// periodic all-bank refresh engine with bounded postponement. Rev 1.0
module dram_cmd_sched #(
  parameter int NUM_OF_BANKS     = 8,
  parameter int REFRESH_INTERVAL = 1024,
  parameter int MAX_POSTPONE     = 4,
  parameter int CNT_WIDTH        = $clog2(REFRESH_INTERVAL),
  parameter int PEND_WIDTH       = $clog2(MAX_POSTPONE + 1)
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    host_req,
  input  logic [1:0]              host_cmd,
  input  logic [NUM_OF_BANKS-1:0] host_bank_sel,
  output logic                    host_gnt,
  output logic                    host_done,
  output logic                    cmd_req,
  output logic [1:0]              cmd,
  output logic [NUM_OF_BANKS-1:0] bank_sel,
  input  logic                    cmd_ack,
  output logic                    refresh_flag,
  output logic [PEND_WIDTH-1:0]   pending_cnt,
  output logic                    refresh_urgent,
  output logic                    refresh_overrun
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HOST_REQ = 3'd1;
  localparam logic [2:0] ST_HOST_REL = 3'd2;
  localparam logic [2:0] ST_REF_REQ  = 3'd3;
  localparam logic [2:0] ST_REF_REL  = 3'd4;

  localparam logic [1:0]            CMD_REFRESH = 2'b11;
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST    = CNT_WIDTH'(REFRESH_INTERVAL - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX    = PEND_WIDTH'(MAX_POSTPONE);

  logic [2:0]              state, state_next;
  logic [CNT_WIDTH-1:0]    interval_cnt;
  logic                    tick;
  logic                    ref_done;
  logic [PEND_WIDTH-1:0]   pend_next;
  logic                    overrun_set;
  logic                    cmd_req_d, host_gnt_d, host_done_d, refresh_flag_d;
  logic [1:0]              cmd_d;
  logic [NUM_OF_BANKS-1:0] bank_sel_d;

  assign tick     = (interval_cnt == CNT_LAST);
  assign ref_done = (state == ST_REF_REL) && !cmd_ack;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b)     interval_cnt <= '0;
    else if (tick) interval_cnt <= '0;
    else           interval_cnt <= interval_cnt + 1'b1;
  end

  // A credit earned and one retired in the same cycle cancel out.
  always_comb begin
    pend_next   = pending_cnt;
    overrun_set = 1'b0;
    if (tick && !ref_done) begin
      if (pending_cnt == PEND_MAX) overrun_set = 1'b1;
      else                         pend_next   = pending_cnt + 1'b1;
    end else if (!tick && ref_done && (pending_cnt != '0)) begin
      pend_next = pending_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      pending_cnt     <= '0;
      refresh_urgent  <= 1'b0;
      refresh_overrun <= 1'b0;
    end else begin
      pending_cnt     <= pend_next;
      refresh_urgent  <= (pend_next == PEND_MAX);
      refresh_overrun <= refresh_overrun | overrun_set;
    end
  end

  // State register; outputs are registered from the next-state decode.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state        <= ST_IDLE;
      cmd_req      <= 1'b0;
      host_gnt     <= 1'b0;
      host_done    <= 1'b0;
      refresh_flag <= 1'b0;
      cmd          <= '0;
      bank_sel     <= '0;
    end else begin
      state        <= state_next;
      cmd_req      <= cmd_req_d;
      host_gnt     <= host_gnt_d;
      host_done    <= host_done_d;
      refresh_flag <= refresh_flag_d;
      cmd          <= cmd_d;
      bank_sel     <= bank_sel_d;
    end
  end

  // IDLE only issues once the previous ack has been withdrawn.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (!cmd_ack) begin
          if (refresh_urgent)          state_next = ST_REF_REQ;
          else if (host_req)           state_next = ST_HOST_REQ;
          else if (pending_cnt != '0)  state_next = ST_REF_REQ;
        end
      end
      ST_HOST_REQ: if (cmd_ack)  state_next = ST_HOST_REL;
      ST_HOST_REL: if (!cmd_ack) state_next = ST_IDLE;
      ST_REF_REQ:  if (cmd_ack)  state_next = ST_REF_REL;
      ST_REF_REL:  if (!cmd_ack) state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_req_d      = (state_next == ST_HOST_REQ) || (state_next == ST_REF_REQ);
    host_gnt_d     = (state_next == ST_HOST_REQ) || (state_next == ST_HOST_REL);
    refresh_flag_d = (state_next == ST_REF_REQ)  || (state_next == ST_REF_REL);
    host_done_d    = (state == ST_HOST_REL) && (state_next == ST_IDLE);
    cmd_d          = cmd;
    bank_sel_d     = bank_sel;
    if ((state == ST_IDLE) && (state_next == ST_HOST_REQ)) begin
      cmd_d      = host_cmd;
      bank_sel_d = host_bank_sel;
    end else if ((state == ST_IDLE) && (state_next == ST_REF_REQ)) begin
      cmd_d      = CMD_REFRESH;
      bank_sel_d = '1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_cmd_sched.sv
`default_nettype none
// tb_dram_cmd_sched: scoreboard bench; expected command issues and status
// values are queued by the stimulus and checked by an independent monitor.
module tb_dram_cmd_sched;

  localparam int NB = 8;
  localparam int PW = 2;

  localparam int S_PEND = 0, S_URG = 1, S_OVR = 2, S_REQ = 3, S_RFLAG = 4,
                 S_HDONE = 5, S_RSTV = 6, S_EVQ = 7;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          host_req;
  logic [1:0]    host_cmd;
  logic [NB-1:0] host_bank_sel;
  logic          host_gnt, host_done, cmd_req, refresh_flag;
  logic [1:0]    cmd;
  logic [NB-1:0] bank_sel;
  logic          cmd_ack;
  logic [PW-1:0] pending_cnt;
  logic          refresh_urgent, refresh_overrun;

  logic ack_auto, ack_man, ack_dly;
  int   cyc;

  dram_cmd_sched #(
    .NUM_OF_BANKS(NB), .REFRESH_INTERVAL(16), .MAX_POSTPONE(2)
  ) dut (
    .clk(clk), .rst_b(rst_b),
    .host_req(host_req), .host_cmd(host_cmd), .host_bank_sel(host_bank_sel),
    .host_gnt(host_gnt), .host_done(host_done),
    .cmd_req(cmd_req), .cmd(cmd), .bank_sel(bank_sel), .cmd_ack(cmd_ack),
    .refresh_flag(refresh_flag), .pending_cnt(pending_cnt),
    .refresh_urgent(refresh_urgent), .refresh_overrun(refresh_overrun)
  );

  always #5 clk = ~clk;

  // DRAM model: ack follows cmd_req one cycle later, or is driven directly.
  always @(posedge clk) ack_dly <= cmd_req;
  assign cmd_ack = ack_auto ? ack_dly : ack_man;

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct { int cyc; logic is_ref; logic [1:0] cmd; logic [NB-1:0] bank; } ev_t;
  typedef struct { string name; int sel; int exp; } st_t;

  ev_t ev_q[$];
  st_t st_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic expect_ev(input int c, input logic r, input logic [1:0] cm, input logic [NB-1:0] bk);
    ev_t e;
    e.cyc = c; e.is_ref = r; e.cmd = cm; e.bank = bk;
    ev_q.push_back(e);
  endtask

  task automatic chk(input string name, input int sel, input int exp);
    st_t s;
    s.name = name; s.sel = sel; s.exp = exp;
    st_q.push_back(s);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", S_RSTV, 0);
    rst_b = 1'b0;
  endtask

  function automatic int actual(input int sel);
    case (sel)
      S_PEND:  return int'(pending_cnt);
      S_URG:   return int'(refresh_urgent);
      S_OVR:   return int'(refresh_overrun);
      S_REQ:   return int'(cmd_req);
      S_RFLAG: return int'(refresh_flag);
      S_HDONE: return int'(host_done);
      S_RSTV:  return int'({cmd_req, cmd, bank_sel, host_gnt, host_done, refresh_flag,
                            pending_cnt, refresh_urgent, refresh_overrun});
      S_EVQ:   return ev_q.size();
      default: return -1;
    endcase
  endfunction

  // Monitor: samples 1 time unit after each negedge or reset assertion.
  logic          req_q = 1'b0;
  logic          hold_ok = 1'b0;
  logic [1:0]    hold_cmd = '0;
  logic [NB-1:0] hold_bank = '0;

  always begin
    @(negedge clk or posedge rst_b);
    #1;
    while (st_q.size() > 0) begin
      st_t s;
      int  a;
      s = st_q.pop_front();
      a = actual(s.sel);
      n_cmp++;
      if (a != s.exp) begin
        n_err++;
        $display("FAIL %s @cyc %0d: got %0d, want %0d", s.name, cyc, a, s.exp);
      end
    end
    if (cmd_req && !req_q) begin
      n_cmp++;
      if (ev_q.size() == 0) begin
        n_err++;
        hold_ok = 1'b0;
        $display("FAIL unexpected_cmd_req @cyc %0d: cmd=%0d bank=%02h ref=%0b", cyc, cmd, bank_sel, refresh_flag);
      end else begin
        ev_t e;
        e = ev_q.pop_front();
        if (cyc != e.cyc || cmd != e.cmd || bank_sel != e.bank ||
            refresh_flag != e.is_ref || host_gnt != !e.is_ref) begin
          n_err++;
          $display("FAIL cmd_issue: got cyc=%0d cmd=%0d bank=%02h ref=%0b gnt=%0b, want cyc=%0d cmd=%0d bank=%02h ref=%0b gnt=%0b",
                   cyc, cmd, bank_sel, refresh_flag, host_gnt, e.cyc, e.cmd, e.bank, e.is_ref, !e.is_ref);
        end
        hold_ok = 1'b1; hold_cmd = e.cmd; hold_bank = e.bank;
      end
    end else if (cmd_req && hold_ok) begin
      n_cmp++;
      if (cmd != hold_cmd || bank_sel != hold_bank) begin
        n_err++;
        $display("FAIL cmd_stable @cyc %0d: got cmd=%0d bank=%02h, want cmd=%0d bank=%02h",
                 cyc, cmd, bank_sel, hold_cmd, hold_bank);
      end
    end
    req_q = cmd_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    rst_b = 1'b1; host_req = 1'b0; host_cmd = 2'd0; host_bank_sel = '0;
    ack_auto = 1'b1; ack_man = 1'b0;

    // Idle refresh cadence
    expect_ev(17, 1'b1, 2'b11, 8'hFF);
    expect_ev(33, 1'b1, 2'b11, 8'hFF);
    expect_ev(49, 1'b1, 2'b11, 8'hFF);
    do_reset();
    wait_cyc(15); chk("pend_pre_tick", S_PEND, 0);
    wait_cyc(16); chk("pend_first_tick", S_PEND, 1);
    wait_cyc(20); chk("pend_in_rel", S_PEND, 1); chk("rflag_in_rel", S_RFLAG, 1);
    wait_cyc(21); chk("pend_after_refdone", S_PEND, 0); chk("rflag_done", S_RFLAG, 0);
    wait_cyc(55);

    // Continuous host traffic forced to yield at urgency
    host_req = 1'b1; host_cmd = 2'd1; host_bank_sel = 8'h04;
    do_reset();
    for (int c = 1; c <= 31; c += 5) expect_ev(c, 1'b0, 2'd1, 8'h04);
    expect_ev(36, 1'b1, 2'b11, 8'hFF);
    expect_ev(41, 1'b0, 2'd1, 8'h04);
    expect_ev(46, 1'b0, 2'd1, 8'h04);
    expect_ev(51, 1'b1, 2'b11, 8'hFF);
    expect_ev(56, 1'b0, 2'd1, 8'h04);
    wait_cyc(31); chk("urg_before", S_URG, 0);
    wait_cyc(35); chk("pend_sat", S_PEND, 2); chk("urg_set", S_URG, 1);
    wait_cyc(40); chk("pend_after_urgref", S_PEND, 1); chk("urg_clr", S_URG, 0);
    wait_cyc(58);

    // Host wins over a non-urgent credit; inputs latched at grant
    host_req = 1'b0;
    do_reset();
    expect_ev(17, 1'b0, 2'd2, 8'h81);
    expect_ev(22, 1'b1, 2'b11, 8'hFF);
    wait_cyc(16); host_req = 1'b1; host_cmd = 2'd2; host_bank_sel = 8'h81;
    wait_cyc(18); host_cmd = 2'd0; host_bank_sel = 8'h00;
    wait_cyc(20); chk("hdone_early", S_HDONE, 0);
    wait_cyc(21); chk("hdone_pulse", S_HDONE, 1); chk("pend_host_wait", S_PEND, 1);
    host_req = 1'b0;
    wait_cyc(22); chk("hdone_clear", S_HDONE, 0);
    wait_cyc(27); chk("pend_after_c", S_PEND, 0);

    // Ack withheld: credits saturate and overrun sticks
    ack_auto = 1'b0; ack_man = 1'b0;
    do_reset();
    expect_ev(17, 1'b1, 2'b11, 8'hFF);
    wait_cyc(32); chk("pend_two", S_PEND, 2); chk("urg_two", S_URG, 1); chk("ovr_none", S_OVR, 0);
    wait_cyc(47); chk("ovr_pre", S_OVR, 0);
    wait_cyc(48); chk("ovr_set", S_OVR, 1); chk("pend_held", S_PEND, 2);
    wait_cyc(57); chk("req_held", S_REQ, 1); chk("ovr_sticky", S_OVR, 1);

    // Asynchronous reset mid-refresh with ack still high
    ack_man = 1'b1; host_req = 1'b1; host_cmd = 2'b11; host_bank_sel = 8'h10;
    #2;
    chk("async_req", S_REQ, 0); chk("async_rflag", S_RFLAG, 0); chk("async_ovr", S_OVR, 0);
    rst_b = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("reset_state_e", S_RSTV, 0);
    rst_b = 1'b0;
    expect_ev(6, 1'b0, 2'b11, 8'h10);
    expect_ev(17, 1'b1, 2'b11, 8'hFF);
    for (int c = 1; c <= 5; c++) begin
      wait_cyc(c); chk("no_req_while_ack", S_REQ, 0);
    end
    ack_man = 1'b0; ack_auto = 1'b1;
    wait_cyc(10); chk("hdone_e", S_HDONE, 1);
    host_req = 1'b0;
    wait_cyc(11); chk("host_refcmd_no_credit", S_PEND, 0);
    wait_cyc(21); chk("pend_e_done", S_PEND, 0);

    // Tick coincident with ref_done at one credit
    ack_auto = 1'b0; ack_man = 1'b0;
    do_reset();
    expect_ev(17, 1'b1, 2'b11, 8'hFF);
    expect_ev(33, 1'b1, 2'b11, 8'hFF);
    wait_cyc(28); ack_man = 1'b1;
    wait_cyc(30); chk("rflag_f_rel", S_RFLAG, 1);
    wait_cyc(31); chk("pend_f_pre", S_PEND, 1);
    ack_man = 1'b0;
    wait_cyc(32); chk("pend_coincident", S_PEND, 1); chk("ovr_coincident", S_OVR, 0);
    chk("rflag_f_idle", S_RFLAG, 0);
    wait_cyc(36);

    chk("events_left", S_EVQ, 0);
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
